// File: rtl/accel_spi_driver.sv
// SPI mode-3 master for an accelerometer: one config write after reset, then
// back-to-back reads of a single signed byte, each published with a strobe.
module accel_spi_driver #(
   parameter int         CLK_DIV    = 4,
   parameter int         GAP_CYCLES = 16,
   parameter logic [5:0] CFG_ADDR   = 6'h20,
   parameter logic [7:0] CFG_DATA   = 8'h57,
   parameter logic [5:0] DATA_ADDR  = 6'h29
) (
   input  logic       sys_clock,
   input  logic       reset,
   input  logic       enable,
   output logic       mosi,
   input  logic       miso,
   output logic       scl,
   output logic       cs,
   output logic       accel_osync,
   output logic [7:0] accel_value
);
   localparam int             CNT_MAX    = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int             CW         = $clog2(CNT_MAX) + 1;
   localparam logic [CW-1:0]  DIV_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]  GAP_LAST   = CW'(GAP_CYCLES - 1);
   localparam logic [5:0]     LAST_PHASE = 6'd33;
   localparam logic [15:0]    CFG_WORD   = {2'b00, CFG_ADDR, CFG_DATA};
   localparam logic [15:0]    READ_WORD  = {2'b10, DATA_ADDR, 8'h00};

   typedef enum logic [2:0] {IDLE, CFG, GAP, READ, HOLD} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [5:0]      phase_q, phase_d;
   logic [15:0]     tx_q, tx_d;
   logic [7:0]      rx_q, rx_d;
   logic [7:0]      value_q, value_d;
   logic            cs_q, cs_d, scl_q, scl_d, mosi_q, mosi_d, osync_q, osync_d;
   logic            phase_end, start_read;

   // A frame is 34 phases of CLK_DIV cycles: 0 = setup, odd 1..31 = scl low,
   // even 2..32 = scl high, 33 = hold. Edges happen on phase boundaries.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      value_d    = value_q;
      cs_d       = cs_q;
      scl_d      = scl_q;
      mosi_d     = mosi_q;
      osync_d    = 1'b0;
      start_read = 1'b0;
      phase_end  = (cnt_q == DIV_LAST);
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = CFG;
               cs_d    = 1'b0;
               cnt_d   = '0;
               phase_d = '0;
               tx_d    = CFG_WORD;
            end
         end
         CFG, READ: begin
            cnt_d = phase_end ? '0 : cnt_q + 1'b1;
            if (phase_end) begin
               phase_d = phase_q + 6'd1;
               if (phase_q == LAST_PHASE) begin
                  cs_d    = 1'b1;
                  state_d = GAP;
                  if (state_q == READ) begin
                     value_d = rx_q;
                     osync_d = 1'b1;
                  end
               end else if (phase_q[0]) begin
                  scl_d = 1'b1;
                  // only the second byte of a frame carries read data
                  if (phase_q >= 6'd17) rx_d = {rx_q[6:0], miso};
               end else if (phase_q != 6'd32) begin
                  scl_d  = 1'b0;
                  mosi_d = tx_q[15];
                  tx_d   = {tx_q[14:0], 1'b0};
               end
            end
         end
         GAP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == GAP_LAST) begin
               if (enable) start_read = 1'b1;
               else        state_d    = HOLD;
            end
         end
         HOLD: begin
            if (enable) start_read = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (start_read) begin
         state_d = READ;
         cs_d    = 1'b0;
         cnt_d   = '0;
         phase_d = '0;
         tx_d    = READ_WORD;
      end
   end

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         phase_q <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         value_q <= '0;
         cs_q    <= 1'b1;
         scl_q   <= 1'b1;
         mosi_q  <= 1'b0;
         osync_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         value_q <= value_d;
         cs_q    <= cs_d;
         scl_q   <= scl_d;
         mosi_q  <= mosi_d;
         osync_q <= osync_d;
      end
   end

   assign mosi        = mosi_q;
   assign scl         = scl_q;
   assign cs          = cs_q;
   assign accel_osync = osync_q;
   assign accel_value = value_q;

endmodule

// File: tb/tb_accel_spi_driver.sv
// Directed bench for accel_spi_driver with a mode-3 SPI slave model and a
// frame monitor that records length, edges and the mosi word of each frame.
module tb_accel_spi_driver;
   logic       sys_clock = 1'b0;
   logic       reset     = 1'b1;
   logic       enable    = 1'b1;
   logic       miso      = 1'b0;
   logic       mosi, scl, cs, accel_osync;
   logic [7:0] accel_value;

   int checks   = 0;
   int failures = 0;

   accel_spi_driver dut (
      .sys_clock   (sys_clock),
      .reset       (reset),
      .enable      (enable),
      .mosi        (mosi),
      .miso        (miso),
      .scl         (scl),
      .cs          (cs),
      .accel_osync (accel_osync),
      .accel_value (accel_value)
   );

   always #5 sys_clock = ~sys_clock;

   // monitor / slave state
   logic        mon_en     = 1'b0;
   logic        prev_cs    = 1'b1;
   logic        prev_scl   = 1'b1;
   logic        prev_mosi  = 1'b0;
   logic [7:0]  slave_byte = 8'h00;
   logic [7:0]  slave_sh   = 8'h00;
   logic [15:0] mosi_word  = 16'h0;
   logic [15:0] last_mosi  = 16'h0;
   logic        end_osync  = 1'b0;
   logic [7:0]  end_val    = 8'h00;
   int flen = 0, falls = 0, last_len = 0, last_falls = 0;
   int gap_len = 0, last_gap = 0;
   int frame_cnt = 0, start_cnt = 0, osync_cnt = 0;
   int scl_cs_err = 0, mosi_err = 0;

   always @(negedge sys_clock) begin
      if (mon_en) begin
         if (cs === 1'b1 && scl !== 1'b1) scl_cs_err++;
         if (cs === 1'b0 && prev_scl === 1'b1 && scl === 1'b1 && mosi !== prev_mosi) mosi_err++;
         if (accel_osync === 1'b1) osync_cnt++;
         if (prev_cs === 1'b1 && cs === 1'b0) begin
            flen      = 1;
            falls     = 0;
            mosi_word = 16'h0;
            slave_sh  = slave_byte;
            last_gap  = gap_len;
            start_cnt++;
         end else if (cs === 1'b0) begin
            flen++;
         end else if (prev_cs === 1'b0 && cs === 1'b1) begin
            last_len   = flen;
            last_falls = falls;
            last_mosi  = mosi_word;
            end_osync  = accel_osync;
            end_val    = accel_value;
            gap_len    = 1;
            frame_cnt++;
         end else begin
            gap_len++;
         end
         // slave shifts its byte out on falling edges 8..15
         if (cs === 1'b0 && prev_scl === 1'b1 && scl === 1'b0) begin
            if (falls >= 8) begin
               miso     = slave_sh[7];
               slave_sh = {slave_sh[6:0], 1'b0};
            end else begin
               miso = 1'b0;
            end
            falls++;
         end
         if (cs === 1'b0 && prev_scl === 1'b0 && scl === 1'b1)
            mosi_word = {mosi_word[14:0], mosi};
         prev_cs   = cs;
         prev_scl  = scl;
         prev_mosi = mosi;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clock);
         #1;
      end
   endtask

   task automatic wait_frame(input string tag);
      int start;
      int n;
      start = frame_cnt;
      n = 0;
      while (frame_cnt == start && n < 400) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(frame_cnt != start), 32'd1);
   endtask

   task automatic wait_cs_fall(input string tag);
      int n;
      n = 0;
      while (cs !== 1'b0 && n < 400) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(cs), 32'd0);
   endtask

   int snap;

   initial begin
      // reset held 300 ns
      tick(2);
      mon_en = 1'b1;
      tick(28);
      chk("rst_cs",    32'(cs),          32'd1);
      chk("rst_scl",   32'(scl),         32'd1);
      chk("rst_mosi",  32'(mosi),        32'd0);
      chk("rst_osync", 32'(accel_osync), 32'd0);
      chk("rst_value", 32'(accel_value), 32'd0);
      slave_byte = 8'hA5;
      reset = 1'b0;

      // config frame
      wait_frame("cfg_done");
      chk("cfg_len",   32'(last_len),   32'd136);
      chk("cfg_falls", 32'(last_falls), 32'd16);
      chk("cfg_mosi",  32'(last_mosi),  32'h2057);
      chk("cfg_osync", 32'(end_osync),  32'd0);
      chk("cfg_ocnt",  32'(osync_cnt),  32'd0);

      // first read: 0xA5
      wait_frame("rd1_done");
      chk("rd1_gap",   32'(last_gap),   32'd16);
      chk("rd1_len",   32'(last_len),   32'd136);
      chk("rd1_falls", 32'(last_falls), 32'd16);
      chk("rd1_mosi",  32'(last_mosi),  32'hA900);
      chk("rd1_osync", 32'(end_osync),  32'd1);
      chk("rd1_val",   32'(end_val),    32'hA5);
      chk("rd1_pulse", 32'(accel_osync), 32'd0);
      chk("rd1_hold",  32'(accel_value), 32'hA5);
      chk("rd1_ocnt",  32'(osync_cnt),  32'd1);

      // +127 then -128
      slave_byte = 8'h7F;
      wait_frame("rd2_done");
      chk("rd2_gap",  32'(last_gap),  32'd16);
      chk("rd2_val",  32'(end_val),   32'h7F);
      chk("rd2_ocnt", 32'(osync_cnt), 32'd2);
      slave_byte = 8'h80;
      wait_frame("rd3_done");
      chk("rd3_val",  32'(end_val),   32'h80);
      chk("rd3_ocnt", 32'(osync_cnt), 32'd3);

      // enable dropped 40 cycles into a read frame
      slave_byte = 8'h3C;
      wait_cs_fall("en_start");
      tick(40);
      enable = 1'b0;
      wait_frame("en_done");
      chk("en_len",   32'(last_len),  32'd136);
      chk("en_val",   32'(end_val),   32'h3C);
      chk("en_osync", 32'(end_osync), 32'd1);
      chk("en_ocnt",  32'(osync_cnt), 32'd4);
      snap = start_cnt;
      tick(100);
      chk("hold_cs",     32'(cs),        32'd1);
      chk("hold_starts", 32'(start_cnt), 32'(snap));
      slave_byte = 8'h12;
      enable = 1'b1;
      wait_frame("res_done");
      chk("res_mosi", 32'(last_mosi), 32'hA900);
      chk("res_val",  32'(end_val),   32'h12);
      chk("res_ocnt", 32'(osync_cnt), 32'd5);

      // reset 50 cycles into a frame
      slave_byte = 8'h55;
      wait_cs_fall("mr_start");
      tick(50);
      reset = 1'b1;
      tick(1);
      chk("mr_cs",    32'(cs),          32'd1);
      chk("mr_scl",   32'(scl),         32'd1);
      chk("mr_value", 32'(accel_value), 32'd0);
      chk("mr_osync", 32'(accel_osync), 32'd0);
      chk("mr_mosi",  32'(mosi),        32'd0);
      tick(3);
      snap = osync_cnt;
      chk("mr_ocnt", 32'(osync_cnt), 32'd5);
      reset = 1'b0;
      wait_frame("mr_cfg_done");
      chk("mr_cfg_len",   32'(last_len),  32'd136);
      chk("mr_cfg_mosi",  32'(last_mosi), 32'h2057);
      chk("mr_cfg_osync", 32'(end_osync), 32'd0);
      chk("mr_cfg_ocnt",  32'(osync_cnt), 32'(snap));
      wait_frame("mr_rd_done");
      chk("mr_rd_mosi", 32'(last_mosi), 32'hA900);
      chk("mr_rd_val",  32'(end_val),   32'h55);
      chk("mr_rd_ocnt", 32'(osync_cnt), 32'd6);

      chk("scl_while_cs_high", 32'(scl_cs_err), 32'd0);
      chk("mosi_stable_high",  32'(mosi_err),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/accel_spi_driver.md
Name: accel_spi_driver

Overview:
- SPI master that configures an external 3-axis accelerometer once after reset, then continuously reads one 8-bit signed acceleration register.
- Presents each sample on a parallel bus together with a one-cycle strobe.
- Sits between the board SPI pins (accelerometer or bench SPI slave model) and the vibration-processing logic.
- Single clock domain (sys_clock); SCL is derived by counting sys_clock cycles.

Parameters:
- CLK_DIV, 4, sys_clock cycles per SCL half-period (≥2).
- GAP_CYCLES, 16, minimum sys_clock cycles CS stays high between frames.
- CFG_ADDR, 6'h20, register address written once after reset.
- CFG_DATA, 8'h57, value written to CFG_ADDR.
- DATA_ADDR, 6'h29, register read repeatedly (acceleration high byte).

Ports:
- sys_clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = run sampling loop; 0 = stop after current frame.
- mosi  out  1  SPI master-out data.
- miso  in  1  SPI master-in data.
- scl  out  1  SPI clock, idles high.
- cs  out  1  SPI chip select, active low.
- accel_osync  out  1  one-cycle pulse when accel_value updates.
- accel_value  out  8  signed sample, two's complement.

Behaviour:
- Reset values: cs=1, scl=1, mosi=0, accel_osync=0, accel_value=0; state=IDLE. All outputs are registered.
- SPI mode 3 (CPOL=1, CPHA=1), MSB first, 16-bit frames.
  - mosi changes only on the scl falling edge.
  - miso is sampled on the scl rising edge.
- Frame timing, in sys_clock cycles after cs falls:
  - CLK_DIV cycles setup with scl high.
  - 16 bits follow. For each bit, scl is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - After the last rising edge, CLK_DIV cycles hold, then cs=1.
  - Total frame = 34*CLK_DIV cycles (136 with defaults).
- Byte 0 = {RW, MB=0, addr[5:0]}, where RW=1 for read. Byte 1 = write data, or 8'h00 during a read.
- States:
  - IDLE: cs=1. When enable=1, go to CFG.
  - CFG: write frame {0,0,CFG_ADDR}, CFG_DATA. Then go to GAP.
  - GAP: cs=1 for GAP_CYCLES. Then go to READ if enable=1, otherwise HOLD.
  - READ: read frame {1,0,DATA_ADDR}, 8'h00. miso bits 8..15 are shifted into an 8-bit register, MSB first. Then go to GAP.
  - HOLD: cs=1. When enable=1, go to READ; the config frame is not repeated.
- Sample output: in the cycle cs returns high after a READ frame, accel_value takes the captured byte and accel_osync=1 for exactly that one cycle. accel_value holds until the next completed read.
- enable deasserted mid-frame: the current frame completes normally, including its sample update. Sampling then stops in HOLD.
- Reset mid-frame: the next edge forces reset values (cs=1, scl=1 immediately, frame aborted, no strobe). The config frame is re-sent after reset releases.
- Sample rate with defaults: one sample per 136+16=152 cycles.
- miso is treated as synchronous to scl; no input synchroniser is required.
- scl never glitches: exactly 16 falling edges per frame, and none while cs=1.

Test Plan:
- Reset held 300 ns then released, enable=1 → first frame: cs low for 136 cycles, 16 scl pulses, mosi bytes 0x20, 0x57; no accel_osync pulse.
- Bench slave drives 0xA5 on read data → second frame mosi byte 0 = 0xA9; at frame end accel_value=8'hA5 (−91) with one-cycle accel_osync; following frames repeat every 152 cycles.
- Slave returns 0x7F then 0x80 on successive reads → accel_value=+127 then −128; exactly one strobe per frame.
- enable dropped 40 cycles into a read frame → frame completes and updates accel_value; cs stays high while enable=0. enable re-raised → read frame (0xA9) starts after HOLD; no config frame.
- reset asserted 50 cycles into a frame → next cycle cs=1, scl=1, accel_value=0, no strobe. After release, config frame 0x20/0x57 is sent again.
- Throughout, check mosi is stable during every scl high phase and scl=1 whenever cs=1.
